// File: rtl/matmul_input_feeder.sv
// Loads NUM_VECS input vectors from RAM into a local buffer, then streams them
// into the systolic array row lanes with a one-lane-per-step diagonal skew.
module matmul_input_feeder #(
  parameter int          ROWS               = 4,
  parameter int          NUM_VECS           = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          MEM_PORT_WIDTH     = 64,
  parameter int          MEM_ACCESS_LATENCY = 2,
  parameter int          BEAT_CYCLES        = 2,
  parameter logic [31:0] INPUT_BASE_ADDR    = 32'h0,
  parameter logic [31:0] MEM_ADDR_INCR      = 32'd4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stall,
  output logic [31:0]               mem_addr,
  output logic                      mem_rd_en,
  input  logic [MEM_PORT_WIDTH-1:0] mem_rd_data,
  output logic [ROWS*WORD_SIZE-1:0] sa_input_bus,
  output logic [ROWS-1:0]           sa_input_valid,
  output logic                      busy,
  output logic                      feed_done
);
  localparam int VEC_W     = ROWS * WORD_SIZE;
  localparam int V_W       = (NUM_VECS > 1) ? $clog2(NUM_VECS) : 1;
  localparam int T_W       = $clog2(NUM_VECS + ROWS);
  localparam int B_W       = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int D_W       = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;
  localparam int LAST_STEP = NUM_VECS + ROWS - 2;

  typedef enum logic [2:0] {IDLE, MEM_RD, MEM_RD_DELAY, FEED, DONE} state_e;

  state_e             state_q, state_d;
  logic [V_W-1:0]     vec_q, vec_d;
  logic [D_W-1:0]     dly_q, dly_d;
  logic [T_W-1:0]     step_q, step_d;
  logic [B_W-1:0]     beat_q, beat_d;
  logic               capture;
  logic [VEC_W-1:0]   vec_buf_q [NUM_VECS];
  logic [VEC_W-1:0]   vec_buf_d [NUM_VECS];

  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [VEC_W-1:0]   sa_input_bus_q, sa_input_bus_d;
  logic [ROWS-1:0]    sa_input_valid_q, sa_input_valid_d;
  logic               busy_q, busy_d;
  logic               feed_done_q, feed_done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    vec_d   = vec_q;
    dly_d   = dly_q;
    step_d  = step_q;
    beat_d  = beat_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEM_RD;
          vec_d   = '0;
        end
      end
      MEM_RD: begin
        dly_d   = D_W'(MEM_ACCESS_LATENCY - 1);
        state_d = MEM_RD_DELAY;
      end
      MEM_RD_DELAY: begin
        if (dly_q == '0) begin
          capture = 1'b1;
          if (vec_q == V_W'(NUM_VECS - 1)) begin
            state_d = FEED;
            vec_d   = '0;
            step_d  = '0;
            beat_d  = '0;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = MEM_RD;
          end
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      FEED: begin
        if (!stall) begin
          if (beat_q == B_W'(BEAT_CYCLES - 1)) begin
            beat_d = '0;
            if (step_q == T_W'(LAST_STEP)) state_d = DONE;
            else                          step_d  = step_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the captured row is bypassed
  // straight into the first feed step when it lands on the same edge.
  always_comb begin
    int diff;
    vec_buf_d = vec_buf_q;
    if (capture) vec_buf_d[vec_q] = mem_rd_data[VEC_W-1:0];

    diff             = 0;
    mem_addr_d       = '0;
    mem_rd_en_d      = 1'b0;
    sa_input_bus_d   = '0;
    sa_input_valid_d = '0;
    busy_d           = (state_d != IDLE);
    feed_done_d      = (state_d == DONE);
    if (state_d == MEM_RD) begin
      mem_rd_en_d = 1'b1;
      mem_addr_d  = INPUT_BASE_ADDR + 32'(vec_d) * MEM_ADDR_INCR;
    end
    if (state_d == FEED) begin
      for (int k = 0; k < ROWS; k++) begin
        diff = int'(step_d) - k;
        if (diff >= 0 && diff < NUM_VECS) begin
          sa_input_valid_d[k] = 1'b1;
          sa_input_bus_d[k*WORD_SIZE +: WORD_SIZE] =
            vec_buf_d[diff[V_W-1:0]][k*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      dly_q            <= '0;
      step_q           <= '0;
      beat_q           <= '0;
      mem_addr_q       <= '0;
      mem_rd_en_q      <= 1'b0;
      sa_input_bus_q   <= '0;
      sa_input_valid_q <= '0;
      busy_q           <= 1'b0;
      feed_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      dly_q            <= dly_d;
      step_q           <= step_d;
      beat_q           <= beat_d;
      mem_addr_q       <= mem_addr_d;
      mem_rd_en_q      <= mem_rd_en_d;
      sa_input_bus_q   <= sa_input_bus_d;
      sa_input_valid_q <= sa_input_valid_d;
      busy_q           <= busy_d;
      feed_done_q      <= feed_done_d;
    end
  end

  // NOTE: the buffer is deliberately not reset; lanes are gated by valid, so
  // stale contents are never visible and the array can map to plain storage.
  always_ff @(posedge clk) begin
    vec_buf_q <= vec_buf_d;
  end

  assign mem_addr       = mem_addr_q;
  assign mem_rd_en      = mem_rd_en_q;
  assign sa_input_bus   = sa_input_bus_q;
  assign sa_input_valid = sa_input_valid_q;
  assign busy           = busy_q;
  assign feed_done      = feed_done_q;

endmodule

// File: tb/tb_matmul_input_feeder.sv
// Self-checking bench for matmul_input_feeder: a per-cycle trace model built from
// the load/skew/beat rules, compared every cycle, plus literal pins on key cycles.
module tb_matmul_input_feeder;
  localparam int ROWS = 4;
  localparam int WS   = 16;
  localparam int MAXC = 64;
  localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd_en;
    logic [63:0] bus;
    logic [3:0]  valid;
    logic        busy;
    logic        done;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stall;
  int   sel;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] m_addr, c_addr;
  logic        m_rd_en, c_rd_en, m_busy, c_busy, m_done, c_done;
  logic [63:0] m_rd_data, c_rd_data, m_bus, c_bus;
  logic [3:0]  m_valid, c_valid;
  logic        m_start, c_start;

  assign m_start = start && (sel == 0);
  assign c_start = start && (sel == 1);

  matmul_input_feeder #(.INPUT_BASE_ADDR(32'h100), .MEM_ADDR_INCR(32'd4)) dut (
    .clk(clk), .rst(rst), .start(m_start), .stall(stall),
    .mem_addr(m_addr), .mem_rd_en(m_rd_en), .mem_rd_data(m_rd_data),
    .sa_input_bus(m_bus), .sa_input_valid(m_valid), .busy(m_busy), .feed_done(m_done)
  );

  matmul_input_feeder #(.NUM_VECS(1), .MEM_ACCESS_LATENCY(1), .BEAT_CYCLES(1),
                        .INPUT_BASE_ADDR(32'h200), .MEM_ADDR_INCR(32'd4)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .stall(stall),
    .mem_addr(c_addr), .mem_rd_en(c_rd_en), .mem_rd_data(c_rd_data),
    .sa_input_bus(c_bus), .sa_input_valid(c_valid), .busy(c_busy), .feed_done(c_done)
  );

  // RAM contents: ram[v][k] is element k of vector v
  logic [15:0] ram [4][4];

  function automatic logic [63:0] ram_row(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    if (idx > 32'd3) return GARBAGE;
    return {ram[idx][3], ram[idx][2], ram[idx][1], ram[idx][0]};
  endfunction

  // RAM read pipelines: data is valid only in the LATENCY-th cycle after the strobe
  logic        mp_v0 = 1'b0, mp_v1 = 1'b0, cp_v = 1'b0;
  logic [31:0] mp_a0 = '0, mp_a1 = '0, cp_a = '0;
  always @(posedge clk) begin
    mp_v0 <= m_rd_en; mp_a0 <= m_addr;
    mp_v1 <= mp_v0;   mp_a1 <= mp_a0;
    cp_v  <= c_rd_en; cp_a  <= c_addr;
  end
  assign m_rd_data = mp_v1 ? ram_row(mp_a1, 32'h100) : GARBAGE;
  assign c_rd_data = cp_v  ? ram_row(cp_a,  32'h200) : GARBAGE;

  // Scenario stimulus, model trace and observed trace, indexed by cycle after start
  bit   start_at [MAXC];
  bit   stall_at [MAXC];
  int   rst_at;
  obs_t exp_tr [MAXC];
  obs_t act_tr [MAXC];
  int   scen;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fill_ram(input logic [15:0] offs);
    for (int v = 0; v < 4; v++)
      for (int k = 0; k < 4; k++)
        ram[v][k] = offs + 16'(v * 16 + k);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      start_at[i] = 1'b0;
      stall_at[i] = 1'b0;
    end
    rst_at = -1;
  endtask

  // Cycle-level trace from the rules: reads every 1+lat cycles, then skewed steps
  // each held 'beat' unstalled cycles, then one done cycle. Returns trace length.
  function automatic int build_exp(input int nv, input int lat, input int beat,
                                   input logic [31:0] base);
    int n, t, b;
    for (int i = 0; i < MAXC; i++) exp_tr[i] = '0;
    for (int v = 0; v < nv; v++) begin
      exp_tr[1 + v * (1 + lat)].rd_en = 1'b1;
      exp_tr[1 + v * (1 + lat)].addr  = base + 32'(4 * v);
    end
    n = 1 + nv * (1 + lat);
    t = 0;
    b = 0;
    while (t <= nv + ROWS - 2) begin
      for (int k = 0; k < ROWS; k++) begin
        if (t - k >= 0 && t - k < nv) begin
          exp_tr[n].valid[k] = 1'b1;
          exp_tr[n].bus[k*WS +: WS] = ram[t - k][k];
        end
      end
      if (!stall_at[n]) begin
        b++;
        if (b == beat) begin
          b = 0;
          t++;
        end
      end
      n++;
    end
    exp_tr[n].done = 1'b1;
    for (int i = 1; i <= n; i++) exp_tr[i].busy = 1'b1;
    if (rst_at >= 0)
      for (int i = rst_at + 1; i < MAXC; i++) exp_tr[i] = '0;
    return n + 3;
  endfunction

  task automatic compare(input int n);
    obs_t a;
    if (sel == 0) a = '{m_addr, m_rd_en, m_bus, m_valid, m_busy, m_done};
    else          a = '{c_addr, c_rd_en, c_bus, c_valid, c_busy, c_done};
    act_tr[n] = a;
    check($sformatf("s%0d.c%0d.addr",  scen, n), 128'(a.addr),  128'(exp_tr[n].addr));
    check($sformatf("s%0d.c%0d.rd_en", scen, n), 128'(a.rd_en), 128'(exp_tr[n].rd_en));
    check($sformatf("s%0d.c%0d.bus",   scen, n), 128'(a.bus),   128'(exp_tr[n].bus));
    check($sformatf("s%0d.c%0d.valid", scen, n), 128'(a.valid), 128'(exp_tr[n].valid));
    check($sformatf("s%0d.c%0d.busy",  scen, n), 128'(a.busy),  128'(exp_tr[n].busy));
    check($sformatf("s%0d.c%0d.done",  scen, n), 128'(a.done),  128'(exp_tr[n].done));
  endtask

  // Called at a negedge in IDLE; cycle 0 is the cycle in which start is driven
  task automatic run(input int s, input int len);
    sel = s;
    for (int n = 0; n < len; n++) begin
      compare(n);
      start = start_at[n];
      stall = stall_at[n];
      rst   = (n == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int len;
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    sel   = 0;
    scen  = 0;
    fill_ram(16'h0000);
    repeat (2) @(negedge clk);
    check("reset_main",   128'({m_addr, m_rd_en, m_bus, m_valid, m_busy, m_done}), 128'(0));
    check("reset_corner", 128'({c_addr, c_rd_en, c_bus, c_valid, c_busy, c_done}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic load and skewed feed
    scen = 1;
    clear_stim();
    start_at[0] = 1'b1;
    len = build_exp(4, 2, 2, 32'h100);
    run(0, len);
    check("basic_busy_rise", 128'({act_tr[0].busy, act_tr[1].busy}), 128'(2'b01));
    check("basic_rd0", 128'({act_tr[1].rd_en, act_tr[1].addr}),   128'({1'b1, 32'h100}));
    check("basic_rd1", 128'({act_tr[4].rd_en, act_tr[4].addr}),   128'({1'b1, 32'h104}));
    check("basic_rd2", 128'({act_tr[7].rd_en, act_tr[7].addr}),   128'({1'b1, 32'h108}));
    check("basic_rd3", 128'({act_tr[10].rd_en, act_tr[10].addr}), 128'({1'b1, 32'h10C}));
    check("basic_step0", 128'({act_tr[13].valid, act_tr[13].bus}), 128'({4'b0001, 64'h0}));
    check("basic_step3a", 128'({act_tr[19].valid, act_tr[19].bus}),
          128'({4'b1111, 64'h0003_0012_0021_0030}));
    check("basic_step3b", 128'({act_tr[20].valid, act_tr[20].bus}),
          128'({4'b1111, 64'h0003_0012_0021_0030}));
    check("basic_step6", 128'({act_tr[25].valid, act_tr[25].bus, act_tr[26].valid, act_tr[26].bus}),
          128'({4'b1000, 64'h0033_0000_0000_0000, 4'b1000, 64'h0033_0000_0000_0000}));
    check("basic_done", 128'({act_tr[26].done, act_tr[27].done, act_tr[28].busy}), 128'(3'b010));

    // Stall during load (no effect) and 5 cycles mid step 2
    scen = 2;
    clear_stim();
    start_at[0] = 1'b1;
    for (int i = 2; i <= 6; i++)   stall_at[i] = 1'b1;
    for (int i = 17; i <= 21; i++) stall_at[i] = 1'b1;
    len = build_exp(4, 2, 2, 32'h100);
    run(0, len);
    check("stall_load_rd3", 128'({act_tr[10].rd_en, act_tr[10].addr}), 128'({1'b1, 32'h10C}));
    check("stall_frozen", 128'({act_tr[21].valid, act_tr[21].bus}),
          128'({4'b0111, 64'h0000_0002_0011_0020}));
    check("stall_done", 128'({act_tr[27].done, act_tr[32].done}), 128'(2'b01));

    // Starts during FEED and DONE are ignored
    scen = 3;
    clear_stim();
    start_at[0]  = 1'b1;
    start_at[16] = 1'b1;
    start_at[27] = 1'b1;
    len = build_exp(4, 2, 2, 32'h100);
    run(0, len);
    check("ign_start_done", 128'({act_tr[27].done, act_tr[28].busy, act_tr[29].rd_en}), 128'(3'b100));

    // Reset at step 4
    scen = 4;
    clear_stim();
    start_at[0] = 1'b1;
    rst_at = 21;
    len = build_exp(4, 2, 2, 32'h100);
    run(0, len);
    check("rst_step4", 128'({act_tr[21].valid, act_tr[21].bus}),
          128'({4'b1110, 64'h0013_0022_0031_0000}));
    check("rst_cleared", 128'(act_tr[22]), 128'(0));

    // Fresh start after reset with new RAM contents
    scen = 5;
    fill_ram(16'h0100);
    clear_stim();
    start_at[0] = 1'b1;
    len = build_exp(4, 2, 2, 32'h100);
    run(0, len);
    check("reload_step3", 128'({act_tr[19].valid, act_tr[19].bus}),
          128'({4'b1111, 64'h0103_0112_0121_0130}));
    check("reload_done", 128'(act_tr[27].done), 128'(1'b1));

    // Parameter corner: latency 1, one beat per step, one vector
    scen = 6;
    clear_stim();
    start_at[0] = 1'b1;
    len = build_exp(1, 1, 1, 32'h200);
    run(1, len);
    check("corner_rd", 128'({act_tr[1].rd_en, act_tr[1].addr, act_tr[2].rd_en}),
          128'({1'b1, 32'h200, 1'b0}));
    check("corner_step0", 128'({act_tr[3].valid, act_tr[3].bus}),
          128'({4'b0001, 64'h0000_0000_0000_0100}));
    check("corner_step3", 128'({act_tr[6].valid, act_tr[6].bus}),
          128'({4'b1000, 64'h0103_0000_0000_0000}));
    check("corner_done", 128'({act_tr[6].done, act_tr[7].done}), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
